grf_mp_sb: RTL and testbench

- Parametrised successor to the D-stage general register file: NUM_RD combinational read ports, one W-stage write port with write-through bypass, and a per-register pending-write scoreboard.
- The scoreboard counts in-flight writers per register so the D-stage stall logic can read busy flags directly.
- Sits in the D stage. Issue comes from D→E handoff, commit from the W-stage write, and flush from branch/exception recovery.

---
 rtl/grf_pkg.sv | 14 +
 rtl/grf_mp_sb_if.sv | 36 +++
 rtl/grf_sb_cnt.sv | 43 ++++
 rtl/grf_mp_sb.sv | 96 +++++++++
 tb/tb_grf_mp_sb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multi-port general register file
// and its pending-write scoreboard.
package grf_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  // Bit offset of port 'port' inside a flattened bus of 'width'-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/grf_mp_sb_if.sv
// Bundle of read ports, the W-stage write port, issue/flush strobes and
// scoreboard status between the D-stage control and the register file.
interface grf_mp_sb_if
  import grf_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 2
);

  // No valid/ready pairs: we, iss_en and flush are single-cycle strobes
  // sampled on every rising clock edge; the file never back-pressures.
  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD-1:0]    rbusy;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [DW-1:0]        wdata;
  logic [31:0]          wpc;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 flush;
  logic                 sb_ovf;
  logic                 sb_unf;

  modport master (
    output raddr, we, waddr, wdata, wpc, iss_en, iss_addr, flush,
    input  rdata, rbusy, sb_ovf, sb_unf
  );

  modport slave (
    input  raddr, we, waddr, wdata, wpc, iss_en, iss_addr, flush,
    output rdata, rbusy, sb_ovf, sb_unf
  );

endinterface

// File: rtl/grf_sb_cnt.sv
// One saturating up/down counter of in-flight writers for a single register.
// ovf_o/unf_o pulse when a lone inc/dec is refused at a bound.
module grf_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/grf_mp_sb.sv
// D-stage register file: NUM_RD combinational read ports with write-through
// bypass, one W-stage write port, and per-register pending-writer counters.
module grf_mp_sb
  import grf_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int NREG     = 32,
  parameter int AW       = AW_DEF,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        reset,
  grf_mp_sb_if.slave bus
);

  logic [DW-1:0]    regs_q [NREG];
  logic [CNT_W-1:0] cnt    [NREG];
  logic [NREG-1:0]  ovf_ev;
  logic [NREG-1:0]  unf_ev;
  logic             sb_ovf_q, sb_ovf_d;
  logic             sb_unf_q, sb_unf_d;
  logic             wr_zero;
  logic             unused_wpc;

  // The writer PC only feeds simulation traces outside this block.
  assign unused_wpc = ^bus.wpc;

  assign wr_zero = (ZERO_REG != 0) && (bus.waddr == AW'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (bus.we && !wr_zero) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    if ((ZERO_REG != 0) && (r == REG_ZERO)) begin : g_tie
      assign cnt[r]    = '0;
      assign ovf_ev[r] = 1'b0;
      assign unf_ev[r] = 1'b0;
    end else begin : g_sb
      logic inc;
      logic dec;
      // Flush wins over both directions; the data write itself still lands.
      assign inc = bus.iss_en && (bus.iss_addr == AW'(r)) && !bus.flush;
      assign dec = bus.we && (bus.waddr == AW'(r)) && !bus.flush;
      grf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc),
        .dec_i (dec),
        .clr_i (bus.flush),
        .cnt_o (cnt[r]),
        .ovf_o (ovf_ev[r]),
        .unf_o (unf_ev[r])
      );
    end
  end

  always_comb begin
    sb_ovf_d = sb_ovf_q | (|ovf_ev);
    sb_unf_d = sb_unf_q | (|unf_ev);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_ovf_q <= 1'b0;
      sb_unf_q <= 1'b0;
    end else begin
      sb_ovf_q <= sb_ovf_d;
      sb_unf_q <= sb_unf_d;
    end
  end

  assign bus.sb_ovf = sb_ovf_q;
  assign bus.sb_unf = sb_unf_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          hit;
    assign ra      = bus.raddr[port_lsb(i, AW) +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == AW'(REG_ZERO));
    assign hit     = bus.we && (bus.waddr == ra);
    assign bus.rdata[port_lsb(i, DW) +: DW] = is_zero ? '0 :
                                              hit     ? bus.wdata : regs_q[ra];
    // The last outstanding writer committing now is already on the bypass.
    assign bus.rbusy[i] = !is_zero && (cnt[ra] != '0) &&
                          !(hit && (cnt[ra] == CNT_W'(1)));
  end

endmodule

// File: tb/tb_grf_mp_sb.sv
// Directed bench for grf_mp_sb: reset, bypass, scoreboard lifecycle,
// saturation/underflow, flush and asynchronous reset mid-cycle.
module tb_grf_mp_sb;
  import grf_pkg::*;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DW-1:0] exp_q  [$];
  logic [AW-1:0] addr_q [$];

  grf_mp_sb_if #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD)) bus ();

  grf_mp_sb #(
    .DW(DW), .NREG(32), .AW(AW), .NUM_RD(NUM_RD), .CNT_W(2), .ZERO_REG(1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] act,
                          input logic [DW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    bus.we     = 1'b0;
    bus.iss_en = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
    cyc();
    bus.iss_en   = 1'b0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    bus.wpc   = 32'h0000_1000 + 32'(a);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.wpc      = '0;
    bus.iss_addr = '0;
    set_ra(0, 5'd9);
    set_ra(1, 5'd17);

    // Reset with arbitrary addresses
    #1 reset = 1'b0;
    #3;
    check_eq("rst_rdata0", rd(0), '0);
    check_eq("rst_rdata1", rd(1), '0);
    check_eq("rst_rbusy", 32'(bus.rbusy), '0);
    check_eq("rst_ovf", 32'(bus.sb_ovf), '0);
    check_eq("rst_unf", 32'(bus.sb_unf), '0);
    @(negedge clk) reset = 1'b1;
    cyc();
    set_ra(0, 5'd5);
    settle();
    check_eq("read_r5", rd(0), '0);

    // Write $8 with a matching issue, bypass on both ports
    issue(5'd8);
    set_ra(0, 5'd8);
    settle();
    check_eq("r8_busy_after_issue", 32'(bus.rbusy[0]), 32'd1);
    drive_wr(5'd8, 32'hDEAD_BEEF);
    set_ra(1, 5'd8);
    settle();
    check_eq("bypass_p0", rd(0), 32'hDEAD_BEEF);
    check_eq("bypass_p1", rd(1), 32'hDEAD_BEEF);
    check_eq("r8_final_writer_busy", 32'(bus.rbusy[0]), '0);
    cyc();
    idle();
    settle();
    check_eq("r8_held", rd(0), 32'hDEAD_BEEF);
    check_eq("r8_idle_busy", 32'(bus.rbusy[0]), '0);

    // Register 0 stays zero
    drive_wr(5'd0, 32'hFFFF_FFFF);
    set_ra(0, 5'd0);
    settle();
    check_eq("r0_no_bypass", rd(0), '0);
    cyc();
    idle();
    settle();
    check_eq("r0_after_write", rd(0), '0);
    check_eq("r0_no_unf", 32'(bus.sb_unf), '0);

    // Scoreboard lifecycle on $3
    issue(5'd3);
    issue(5'd3);
    set_ra(0, 5'd3);
    settle();
    check_eq("r3_busy_cnt2", 32'(bus.rbusy[0]), 32'd1);
    drive_wr(5'd3, 32'h33);
    settle();
    check_eq("r3_busy_commit1", 32'(bus.rbusy[0]), 32'd1);
    check_eq("r3_bypass1", rd(0), 32'h33);
    cyc();
    idle();
    settle();
    check_eq("r3_busy_cnt1", 32'(bus.rbusy[0]), 32'd1);
    drive_wr(5'd3, 32'h34);
    settle();
    check_eq("r3_busy_final", 32'(bus.rbusy[0]), '0);
    check_eq("r3_bypass2", rd(0), 32'h34);
    cyc();
    idle();
    settle();
    check_eq("r3_busy_cnt0", 32'(bus.rbusy[0]), '0);
    check_eq("r3_data", rd(0), 32'h34);
    check_eq("r3_no_flags", 32'({bus.sb_ovf, bus.sb_unf}), '0);

    // Simultaneous issue and commit of $7 at cnt=1
    issue(5'd7);
    set_ra(0, 5'd7);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd7;
    drive_wr(5'd7, 32'h77);
    settle();
    check_eq("r7_both_busy", 32'(bus.rbusy[0]), '0);
    check_eq("r7_both_data", rd(0), 32'h77);
    cyc();
    idle();
    settle();
    check_eq("r7_cnt_held", 32'(bus.rbusy[0]), 32'd1);
    check_eq("r7_no_flags", 32'({bus.sb_ovf, bus.sb_unf}), '0);
    drive_wr(5'd7, 32'h77);
    cyc();
    idle();
    settle();
    check_eq("r7_drained", 32'(bus.rbusy[0]), '0);

    // Saturation on $4
    issue(5'd4);
    issue(5'd4);
    issue(5'd4);
    settle();
    check_eq("r4_no_ovf_at3", 32'(bus.sb_ovf), '0);
    issue(5'd4);
    set_ra(0, 5'd4);
    settle();
    check_eq("r4_ovf", 32'(bus.sb_ovf), 32'd1);
    check_eq("r4_busy_sat", 32'(bus.rbusy[0]), 32'd1);
    drive_wr(5'd4, 32'h40);
    cyc();
    drive_wr(5'd4, 32'h41);
    cyc();
    idle();
    settle();
    check_eq("r4_busy_cnt1", 32'(bus.rbusy[0]), 32'd1);
    drive_wr(5'd4, 32'h42);
    settle();
    check_eq("r4_final_writer", 32'(bus.rbusy[0]), '0);
    cyc();
    idle();
    settle();
    check_eq("r4_cnt0", 32'(bus.rbusy[0]), '0);
    check_eq("r4_no_unf", 32'(bus.sb_unf), '0);

    // Underflow on $9, write still lands
    drive_wr(5'd9, 32'h99);
    cyc();
    idle();
    set_ra(0, 5'd9);
    settle();
    check_eq("r9_unf", 32'(bus.sb_unf), 32'd1);
    check_eq("r9_written", rd(0), 32'h99);
    cyc();
    check_eq("unf_sticky", 32'(bus.sb_unf), 32'd1);
    check_eq("ovf_sticky", 32'(bus.sb_ovf), 32'd1);

    // Flush with concurrent write and issue
    issue(5'd2);
    issue(5'd6);
    set_ra(0, 5'd2);
    set_ra(1, 5'd6);
    settle();
    check_eq("pre_flush_busy", 32'(bus.rbusy), 32'd3);
    bus.flush    = 1'b1;
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd6;
    drive_wr(5'd2, 32'h1);
    cyc();
    idle();
    settle();
    check_eq("post_flush_busy", 32'(bus.rbusy), '0);
    check_eq("flush_write_r2", rd(0), 32'h1);

    // Readback of everything written so far
    addr_q = '{5'd8, 5'd3, 5'd7, 5'd4, 5'd9, 5'd2, 5'd6, 5'd0};
    exp_q  = '{32'hDEAD_BEEF, 32'h34, 32'h77, 32'h42, 32'h99, 32'h1, 32'h0, 32'h0};
    while (exp_q.size() > 0) begin
      set_ra(1, addr_q.pop_front());
      #1;
      check_eq("readback", rd(1), exp_q.pop_front());
    end

    // Asynchronous reset between edges
    cyc();
    issue(5'd5);
    set_ra(0, 5'd9);
    set_ra(1, 5'd5);
    settle();
    check_eq("pre_rst_busy5", 32'(bus.rbusy[1]), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_rdata0", rd(0), '0);
    check_eq("midrst_rbusy", 32'(bus.rbusy), '0);
    check_eq("midrst_flags", 32'({bus.sb_ovf, bus.sb_unf}), '0);
    @(negedge clk) reset = 1'b1;
    cyc();
    set_ra(1, 5'd8);
    settle();
    check_eq("postrst_r9", rd(0), '0);
    check_eq("postrst_r8", rd(1), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
